// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer.
// Executes csrrw/csrrs, ecall, mret, ebreak and illegal-instruction traps,
// and issues a one-cycle redirect to fetch while holding issue.
module csr_trap_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RST_MSTATUS = 64'h0000_000a_0000_1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            unknown_i,
    input  logic [XLEN-1:0] rs1_val_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,
    output logic            halt_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o
);

    localparam logic [6:0]  OPC_SYSTEM  = 7'b111_0011;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

    typedef enum logic {
        ST_IDLE,
        ST_REDIR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_halt;

    logic            w_active;
    logic            w_sys;
    logic            w_illegal;
    logic            w_csrrw;
    logic            w_csrrs;
    logic            w_ecall;
    logic            w_ebreak;
    logic            w_mret;
    logic            w_trap;
    logic            w_event;
    logic [11:0]     w_csr_addr;
    logic [XLEN-1:0] w_csr_rd;
    logic            w_csr_we;
    logic [XLEN-1:0] w_csr_wdata;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_mstatus_mret;
    logic            w_redirect;

    // Instruction decode; everything is qualified by an idle sequencer.
    assign w_active   = valid_i & (r_state == ST_IDLE);
    assign w_sys      = ~unknown_i & (inst_i[6:0] == OPC_SYSTEM);
    assign w_illegal  = w_active & unknown_i;
    assign w_csrrw    = w_active & w_sys & (inst_i[14:12] == 3'd1);
    assign w_csrrs    = w_active & w_sys & (inst_i[14:12] == 3'd2);
    assign w_ecall    = w_active & ~unknown_i & (inst_i == INST_ECALL);
    assign w_ebreak   = w_active & ~unknown_i & (inst_i == INST_EBREAK);
    assign w_mret     = w_active & ~unknown_i & (inst_i == INST_MRET);
    assign w_trap     = w_illegal | w_ecall;
    assign w_event    = w_trap | w_mret;
    assign w_csr_addr = inst_i[31:20];

    // CSR read mux; unmapped addresses read as zero.
    always_comb begin
        w_csr_rd = '0;
        case (w_csr_addr)
            CSR_MSTATUS: w_csr_rd = r_mstatus;
            CSR_MTVEC:   w_csr_rd = r_mtvec;
            CSR_MEPC:    w_csr_rd = r_mepc;
            CSR_MCAUSE:  w_csr_rd = r_mcause;
            default:     w_csr_rd = '0;
        endcase
    end

    // csrrs with rs1 field x0 is a pure read and must not write.
    assign w_csr_we    = w_csrrw | (w_csrrs & (inst_i[19:15] != 5'd0));
    assign w_csr_wdata = w_csrrw ? rs1_val_i : (w_csr_rd | rs1_val_i);

    // mstatus images for trap entry and mret.
    always_comb begin
        w_mstatus_trap           = r_mstatus;
        w_mstatus_trap[MPIE_BIT] = r_mstatus[MIE_BIT];
        w_mstatus_trap[MIE_BIT]  = 1'b0;
        w_mstatus_trap[12:11]    = 2'b11;
        w_mstatus_mret           = r_mstatus;
        w_mstatus_mret[MIE_BIT]  = r_mstatus[MPIE_BIT];
        w_mstatus_mret[MPIE_BIT] = 1'b1;
        w_mstatus_mret[12:11]    = 2'b00;
    end

    // CSR file updates from CSR instructions, traps and mret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus <= RST_MSTATUS;
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else begin
            if (w_csr_we) begin
                case (w_csr_addr)
                    CSR_MSTATUS: r_mstatus <= w_csr_wdata;
                    CSR_MTVEC:   r_mtvec   <= w_csr_wdata;
                    CSR_MEPC:    r_mepc    <= w_csr_wdata;
                    CSR_MCAUSE:  r_mcause  <= w_csr_wdata;
                    default:     ;
                endcase
            end
            if (w_trap) begin
                r_mepc    <= pc_i;
                r_mcause  <= w_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL;
                r_mstatus <= w_mstatus_trap;
            end
            if (w_mret) begin
                r_mstatus <= w_mstatus_mret;
            end
        end
    end

    // Redirect target captured at decode so later CSR writes cannot move it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redir_pc <= '0;
        end else if (w_trap) begin
            r_redir_pc <= {r_mtvec[XLEN-1:2], 2'b00};
        end else if (w_mret) begin
            r_redir_pc <= r_mepc;
        end
    end

    // Sticky halt flag set by ebreak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt <= 1'b0;
        end else if (w_ebreak) begin
            r_halt <= 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state and redirect strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                w_redirect  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign csr_rdata_o   = w_csr_rd;
    assign redirect_o    = w_redirect;
    assign busy_o        = w_redirect;
    assign redirect_pc_o = r_redir_pc;
    assign halt_o        = r_halt;
    assign mstatus_o     = r_mstatus;
    assign mtvec_o       = r_mtvec;
    assign mepc_o        = r_mepc;
    assign mcause_o      = r_mcause;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus random
// instruction streams against a behavioural CSR/trap model, with redirects
// checked by a separate scoreboard monitor.
module tb_csr_trap_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RST_MS = 64'h0000_000a_0000_1800;

    logic            clk;
    logic            rst;
    logic            valid_i;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic            unknown_i;
    logic [XLEN-1:0] rs1_val_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            busy_o;
    logic            halt_o;
    logic [XLEN-1:0] mstatus_o;
    logic [XLEN-1:0] mtvec_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mcause_o;

    csr_trap_unit #(
        .XLEN        (XLEN),
        .RST_MSTATUS (RST_MS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .inst_i        (inst_i),
        .pc_i          (pc_i),
        .unknown_i     (unknown_i),
        .rs1_val_i     (rs1_val_i),
        .csr_rdata_o   (csr_rdata_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .busy_o        (busy_o),
        .halt_o        (halt_o),
        .mstatus_o     (mstatus_o),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .mcause_o      (mcause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model of the architectural state.
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    bit          m_halt;
    bit          m_busy;
    logic [63:0] exp_q[$];

    task automatic m_reset();
        m_mstatus = RST_MS;
        m_mtvec   = '0;
        m_mepc    = '0;
        m_mcause  = '0;
        m_halt    = 0;
        m_busy    = 0;
        exp_q.delete();
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 64'd0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300: m_mstatus = v;
            12'h305: m_mtvec   = v;
            12'h341: m_mepc    = v;
            12'h342: m_mcause  = v;
            default: ;
        endcase
    endtask

    task automatic m_trap(input logic [63:0] pc, input logic [63:0] cause);
        m_mepc         = pc;
        m_mcause       = cause;
        m_mstatus[7]   = m_mstatus[3];
        m_mstatus[3]   = 1'b0;
        m_mstatus[12:11] = 2'b11;
        exp_q.push_back(m_mtvec & ~64'd3);
        m_busy = 1;
    endtask

    // Applies one retiring instruction to the model; checks the CSR read port.
    task automatic m_apply(input logic [31:0] inst, input logic [63:0] pc,
                           input bit unk, input logic [63:0] rs1);
        logic [63:0] old;
        if (unk) begin
            m_trap(pc, 64'd2);
        end else if (inst[6:0] == 7'h73) begin
            if (inst[14:12] == 3'd1 || inst[14:12] == 3'd2) begin
                old = m_read(inst[31:20]);
                chk("csr_rdata", csr_rdata_o, old);
                if (inst[14:12] == 3'd1) m_write(inst[31:20], rs1);
                else if (inst[19:15] != 5'd0) m_write(inst[31:20], old | rs1);
            end else if (inst == 32'h0000_0073) begin
                m_trap(pc, 64'd11);
            end else if (inst == 32'h3020_0073) begin
                exp_q.push_back(m_mepc);
                m_mstatus[3]     = m_mstatus[7];
                m_mstatus[7]     = 1'b1;
                m_mstatus[12:11] = 2'b00;
                m_busy = 1;
            end else if (inst == 32'h0010_0073) begin
                m_halt = 1;
            end
        end
    endtask

    task automatic check_state();
        chk("mstatus", mstatus_o, m_mstatus);
        chk("mtvec",   mtvec_o,   m_mtvec);
        chk("mepc",    mepc_o,    m_mepc);
        chk("mcause",  mcause_o,  m_mcause);
        chk("halt",    {63'd0, halt_o}, {63'd0, m_halt});
        chk("busy",    {63'd0, busy_o}, {63'd0, m_busy});
    endtask

    // One clock of stimulus: check state from the last edge, then drive.
    task automatic drive(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                         input bit unk, input logic [63:0] rs1);
        @(negedge clk);
        check_state();
        valid_i   = v;
        inst_i    = inst;
        pc_i      = pc;
        unknown_i = unk;
        rs1_val_i = rs1;
        #1;
        if (m_busy) m_busy = 0;
        else if (v) m_apply(inst, pc, unk, rs1);
    endtask

    function automatic logic [31:0] csr_inst(input logic [11:0] a, input logic [4:0] rs1f,
                                             input logic [2:0] f3);
        return {a, rs1f, f3, 5'd5, 7'h73};
    endfunction

    // Scoreboard monitor: every redirect cycle must match the next queued target.
    logic [63:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (redirect_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_redirect", {63'd0, redirect_o}, 64'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("redirect_pc", redirect_pc_o, mon_exp);
                        chk("busy_in_redir", {63'd0, busy_o}, 64'd1);
                    end
                end else if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("missing_redirect", {63'd0, redirect_o}, 64'd1);
                end
            end
        end
    end

    logic [11:0] addr_tbl [6];
    logic [31:0] r_inst;
    logic [63:0] r_val;
    int unsigned kind;

    initial begin
        addr_tbl[0] = 12'h300; addr_tbl[1] = 12'h305; addr_tbl[2] = 12'h341;
        addr_tbl[3] = 12'h342; addr_tbl[4] = 12'h7C0; addr_tbl[5] = 12'h001;
        rst = 1'b1; valid_i = 0; inst_i = '0; pc_i = '0; unknown_i = 0; rs1_val_i = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_redirect",    {63'd0, redirect_o}, 64'd0);
        chk("rst_redirect_pc", redirect_pc_o, 64'd0);

        // csrrs x0 on mstatus: pure read of the reset value
        drive(1, csr_inst(12'h300, 5'd0, 3'd2), 64'h100, 0, 64'hFF);
        chk("csrrs_x0_rdata", csr_rdata_o, RST_MS);
        // unmapped CSR reads 0, no trap
        drive(1, csr_inst(12'h7C0, 5'd3, 3'd1), 64'h104, 0, 64'h1234);
        // csrrw mtvec
        drive(1, csr_inst(12'h305, 5'd1, 3'd1), 64'h108, 0, 64'h8000_0103);
        // ecall, then a valid instruction during REDIR that must be ignored
        drive(1, 32'h0000_0073, 64'h8000_0040, 0, '0);
        drive(1, csr_inst(12'h305, 5'd1, 3'd1), 64'h10c, 0, 64'hDEAD);
        chk("ecall_mcause", mcause_o, 64'd11);
        // illegal instruction, then an ignored instruction during REDIR
        drive(1, 32'hFFFF_FFFF, 64'h8000_0010, 1, '0);
        drive(1, csr_inst(12'h342, 5'd1, 3'd1), 64'h110, 0, 64'h77);
        chk("illegal_mcause", mcause_o, 64'd2);
        // mstatus with MPIE=1, then mepc write directly followed by mret
        drive(1, csr_inst(12'h300, 5'd1, 3'd1), 64'h114, 0, 64'h0000_000a_0000_1880);
        drive(1, csr_inst(12'h341, 5'd1, 3'd1), 64'h118, 0, 64'h8000_0200);
        drive(1, 32'h3020_0073, 64'h11c, 0, '0);
        drive(0, '0, '0, 0, '0);
        chk("mret_mstatus", mstatus_o, 64'h0000_000a_0000_0088);
        // ebreak: sticky halt, later instructions still execute
        drive(1, 32'h0010_0073, 64'h120, 0, '0);
        drive(1, csr_inst(12'h342, 5'd2, 3'd2), 64'h124, 0, 64'h40);
        drive(0, '0, '0, 0, '0);
        chk("halt_sticky", {63'd0, halt_o}, 64'd1);
        // reset asserted while in REDIR
        drive(1, 32'h0000_0073, 64'h128, 0, '0);
        @(negedge clk);
        valid_i = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_redir_redirect", {63'd0, redirect_o}, 64'd0);
        chk("rst_in_redir_halt",     {63'd0, halt_o}, 64'd0);
        chk("rst_in_redir_mtvec",    mtvec_o, 64'd0);
        chk("rst_in_redir_mepc",     mepc_o, 64'd0);
        chk("rst_in_redir_mstatus",  mstatus_o, RST_MS);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized instruction stream
        for (int n = 0; n < 600; n++) begin
            kind  = $urandom_range(0, 19);
            r_val = {$urandom, $urandom};
            r_inst = $urandom;
            case (kind)
                0, 1, 2, 3, 4:
                    drive(1, csr_inst(addr_tbl[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 3'd1),
                          r_val, 0, r_val);
                5, 6, 7, 8:
                    drive(1, csr_inst(addr_tbl[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 3'd2),
                          r_val, 0, {$urandom, $urandom});
                9, 10:   drive(1, 32'h0000_0073, r_val, 0, '0);
                11, 12:  drive(1, 32'h3020_0073, r_val, 0, '0);
                13:      drive(1, r_inst, r_val, 1, '0);
                14:      drive($urandom_range(0, 19) == 0, 32'h0010_0073, r_val, 0, '0);
                15, 16:  drive(1, r_inst, r_val, 0, {$urandom, $urandom});
                17:      drive(1, {r_inst[31:7], 7'h73}, r_val, 0, {$urandom, $urandom});
                default: drive(0, r_inst, r_val, $urandom_range(0, 1) == 1, r_val);
            endcase
        end
        drive(0, '0, '0, 0, '0);
        drive(0, '0, '0, 0, '0);
        drive(0, '0, '0, 0, '0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
